// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard for the ID stage: counts in-flight writes
// per architectural register and flags RAW hazards on source operands.

module reg_scoreboard_cell #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             wb_dec,
   input  logic             sq_dec,
   output logic [CNT_W-1:0] cnt,
   output logic             ovf,
   output logic             unf
);
   localparam logic [CNT_W:0] MAX = {1'b0, {CNT_W{1'b1}}};

   logic [CNT_W:0]   up;
   logic [CNT_W:0]   dec;
   logic [CNT_W:0]   res;
   logic [CNT_W-1:0] nxt;

   // One extra bit of headroom so saturation and underflow are detectable.
   assign up  = {1'b0, cnt} + (CNT_W+1)'(inc);
   assign dec = (CNT_W+1)'(wb_dec) + (CNT_W+1)'(sq_dec);

   always_comb begin
      nxt = cnt;
      ovf = 1'b0;
      unf = 1'b0;
      res = '0;
      if (up < dec) begin
         nxt = '0;
         unf = 1'b1;
      end else begin
         res = up - dec;
         if (res > MAX) begin
            nxt = MAX[CNT_W-1:0];
            ovf = 1'b1;
         end else begin
            nxt = res[CNT_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt <= '0;
      else        cnt <= nxt;
   end
endmodule

module reg_scoreboard #(
   parameter int NUM_REGS = 16,
   parameter int ADDR_W   = 4,
   parameter int CNT_W    = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              issue_valid,
   input  logic [ADDR_W-1:0] issue_rd,
   input  logic              wb_valid,
   input  logic [ADDR_W-1:0] wb_rd,
   input  logic              squash_valid,
   input  logic [ADDR_W-1:0] squash_rd,
   input  logic              id_valid,
   input  logic              src1_use,
   input  logic              src2_use,
   input  logic [ADDR_W-1:0] src1_addr,
   input  logic [ADDR_W-1:0] src2_addr,
   output logic              src1_busy,
   output logic              src2_busy,
   output logic              stall,
   output logic              pending_any,
   output logic              ovf_err,
   output logic              unf_err
);
   logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
   logic [NUM_REGS-1:0]            ovf_vec;
   logic [NUM_REGS-1:0]            unf_vec;

   // Register 0 is hardwired zero: no counter, never busy, never errors.
   assign cnt[0]     = '0;
   assign ovf_vec[0] = 1'b0;
   assign unf_vec[0] = 1'b0;

   for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
      reg_scoreboard_cell #(.CNT_W(CNT_W)) u_cell (
         .clk    (clk),
         .rst_n  (rst_n),
         .inc    (issue_valid  && (issue_rd  == ADDR_W'(r))),
         .wb_dec (wb_valid     && (wb_rd     == ADDR_W'(r))),
         .sq_dec (squash_valid && (squash_rd == ADDR_W'(r))),
         .cnt    (cnt[r]),
         .ovf    (ovf_vec[r]),
         .unf    (unf_vec[r])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_err <= 1'b0;
         unf_err <= 1'b0;
      end else begin
         ovf_err <= ovf_err | (|ovf_vec);
         unf_err <= unf_err | (|unf_vec);
      end
   end

   logic [CNT_W-1:0] c1, c2;
   logic             wbhit1, wbhit2;

   assign c1     = cnt[src1_addr];
   assign c2     = cnt[src2_addr];
   assign wbhit1 = wb_valid && (wb_rd == src1_addr);
   assign wbhit2 = wb_valid && (wb_rd == src2_addr);

   // A writeback landing this cycle is bypassed through the RF, so it retires
   // its pending write early; rst_n gating keeps busy low while in reset.
   assign src1_busy = rst_n && src1_use && (src1_addr != '0) && (c1 != CNT_W'(wbhit1));
   assign src2_busy = rst_n && src2_use && (src2_addr != '0) && (c2 != CNT_W'(wbhit2));

   assign stall       = id_valid && (src1_busy || src2_busy);
   assign pending_any = |cnt;
endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Per-register pending-write tracker sitting directly upstream of the 16x16 register file, in the decode (ID) stage. It counts in-flight writes to each architectural register from issue until writeback or squash, and raises a decode stall when a source operand is still pending. Writeback bypass through the register file is honoured: a register whose last pending write completes this cycle is reported not busy.

## Interface
Parameters:
- NUM_REGS, 16, number of architectural registers; register 0 is hardwired zero and never tracked.
- ADDR_W, 4, register address width (log2 NUM_REGS).
- CNT_W, 2, per-register pending-write counter width; saturation value is 2^CNT_W-1 = 3.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- issue_valid  input  1  instruction leaves ID this cycle and will write issue_rd.
- issue_rd  input  ADDR_W  destination of the issuing instruction.
- wb_valid  input  1  register-file write occurs this cycle (drives the RF WriteEnable).
- wb_rd  input  ADDR_W  register being written back.
- squash_valid  input  1  an in-flight writing instruction is killed this cycle.
- squash_rd  input  ADDR_W  destination of the killed instruction.
- id_valid  input  1  valid instruction present in ID.
- src1_use, src2_use  input  1 each  source operand is actually read.
- src1_addr, src2_addr  input  ADDR_W each  source register addresses.
- src1_busy, src2_busy  output  1 each  source operand has an unresolved pending write.
- stall  output  1  hold ID/IF this cycle.
- pending_any  output  1  at least one register has a non-zero counter (used for halt drain).
- ovf_err  output  1  sticky: issue into a saturated counter.
- unf_err  output  1  sticky: decrement of a zero counter.

## Operation
- State: cnt[r] (CNT_W bits) for r = 1..NUM_REGS-1; ovf_err, unf_err flops.
- Per-cycle counter update for each register r != 0: inc = issue_valid & issue_rd==r; dec = (wb_valid & wb_rd==r) + (squash_valid & squash_rd==r), range 0..2; next = cnt + inc - dec.
- Simultaneous inc and dec on the same register net out (e.g. cnt 1, issue+wb same reg -> stays 1).
- Saturation: if cnt==3 and net change is +1, cnt stays 3 and ovf_err sets.
- Underflow: if net decrement exceeds cnt, cnt clamps to 0 and unf_err sets.
- Any event addressed to register 0 is ignored; it never changes state or sets an error.
- Busy (combinational): srcN_busy = srcN_use & srcN_addr!=0 & (cnt[srcN_addr] - wbhit) != 0, where wbhit = wb_valid & wb_rd==srcN_addr (writeback bypass). Squash in the same cycle does not clear busy.
- stall = id_valid & (src1_busy | src2_busy).
- pending_any = OR over all cnt[r] != 0 (registered state only, no bypass).
- issue_valid asserted while stall is high is a protocol violation by the pipeline; the block still counts it.
- ovf_err/unf_err clear only on reset.

## Timing
- Reset (async assert, sync-to-clk deassert by the reset generator): all cnt = 0; ovf_err = unf_err = 0; consequently src1_busy = src2_busy = stall = pending_any = 0.
- Reset asserted mid-operation drops all pending state immediately; no outputs glitch high during reset.
- Counter and error-flag updates take effect at the next rising edge (1-cycle latency from issue to busy).
- src*_busy, stall: combinational from current counters and current-cycle wb_valid/wb_rd; no registered delay.
- pending_any: reflects counters only, so it deasserts the cycle after the final writeback.

## Test plan
- Reset: drive rst_n=0 mid-run with cnt[5]=2 -> all outputs 0 immediately, cnt[5]=0 after release.
- RAW stall: issue rd=3; next cycle id_valid, src1_use, src1_addr=3, no wb -> stall=1; cycle with wb_valid, wb_rd=3 -> src1_busy=0, stall=0 (bypass); following cycle pending_any=0.
- Multiple in-flight: issue rd=7 twice, then wb rd=7 once -> src2_busy (addr 7) stays 1; second wb -> 0; simultaneous issue+wb rd=7 at cnt 1 -> cnt stays 1.
- Squash: issue rd=9, squash_valid rd=9 -> cnt[9]=0, no error; wb rd=9 later -> unf_err=1, cnt stays 0.
- Saturation and R0: four issues to rd=2 without wb -> cnt=3, ovf_err=1; issue/wb/src reads on register 0 -> no busy, no error, stall=0.
- Unused source: src1_use=0, src1_addr busy -> src1_busy=0, stall=0.
